// File: rtl/io_entry_ctrl_if.sv
// rtl/io_entry_ctrl_if.sv - key, CPU hand-off and display signals of io_entry_ctrl
interface io_entry_if #(
  parameter int DW = 32
);
  logic          k1_ten;
  logic          k2_ge;
  logic          k_enter;
  logic          k_cancel;
  logic          cpu_take_i;
  logic          out_i;
  logic [DW-1:0] res_i;
  logic [DW-1:0] pc_i;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic [DW-1:0] disp_o;
  logic [1:0]    disp_sel_o;
  logic [1:0]    state_o;

  modport master (
    output k1_ten, k2_ge, k_enter, k_cancel, cpu_take_i, out_i, res_i, pc_i,
    input  data_o, data_valid_o, disp_o, disp_sel_o, state_o
  );

  modport slave (
    input  k1_ten, k2_ge, k_enter, k_cancel, cpu_take_i, out_i, res_i, pc_i,
    output data_o, data_valid_o, disp_o, disp_sel_o, state_o
  );
endinterface

// File: rtl/io_entry_ctrl.sv
// rtl/io_entry_ctrl.sv - key debounce, decimal entry, CPU hand-off and display select
module io_entry_ctrl #(
  parameter int DB_CYCLES = 200,
  parameter int DW        = 32
) (
  input logic       clk,
  input logic       rst,
  io_entry_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  // Key bit order: 3 cancel, 2 enter, 1 ten, 0 ge (also the press priority order)
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_press;

  state_t        r_state,   w_state_n;
  logic [3:0]    r_tens,    w_tens_n;
  logic [3:0]    r_ones,    w_ones_n;
  logic [DW-1:0] r_data,    w_data_n;
  logic          r_valid,   w_valid_n;
  logic          r_show_pc, w_show_pc_n;
  logic [DW-1:0] r_res,     w_res_n;
  logic [DW-1:0] r_pc,      w_pc_n;
  logic [6:0]    w_value;
  logic [DW-1:0] w_value_ext;

  assign w_raw       = {bus.k_cancel, bus.k_enter, bus.k1_ten, bus.k2_ge};
  assign w_value     = 7'(r_tens) * 7'd10 + 7'(r_ones);
  assign w_value_ext = {{(DW - 7){1'b0}}, w_value};

  // Synchronize keys, count stable-high cycles, fire one press as the count reaches DB_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= r_sync2[i] && (r_cnt[i] == CW'(DB_CYCLES - 1));
        if (!r_sync2[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] != CW'(DB_CYCLES))
          r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ENTRY;
      r_tens    <= '0;
      r_ones    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_show_pc <= 1'b0;
      r_res     <= '0;
      r_pc      <= '0;
    end else begin
      r_state   <= w_state_n;
      r_tens    <= w_tens_n;
      r_ones    <= w_ones_n;
      r_data    <= w_data_n;
      r_valid   <= w_valid_n;
      r_show_pc <= w_show_pc_n;
      r_res     <= w_res_n;
      r_pc      <= w_pc_n;
    end
  end

  // Next state: prioritized key press and take first, then a result strobe overrides the state
  always_comb begin
    w_state_n   = r_state;
    w_tens_n    = r_tens;
    w_ones_n    = r_ones;
    w_data_n    = r_data;
    w_valid_n   = r_valid;
    w_show_pc_n = r_show_pc;
    w_res_n     = r_res;
    w_pc_n      = r_pc;
    case (r_state)
      ST_ENTRY: begin
        if (r_press[3]) begin
          w_tens_n = '0;
          w_ones_n = '0;
        end else if (r_press[2]) begin
          w_data_n  = w_value_ext;
          w_valid_n = 1'b1;
          w_state_n = ST_PENDING;
        end else if (r_press[1]) begin
          w_tens_n = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else if (r_press[0]) begin
          w_ones_n = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
        end
      end
      ST_PENDING: begin
        if (bus.cpu_take_i) begin
          w_valid_n = 1'b0;
          w_tens_n  = '0;
          w_ones_n  = '0;
          w_state_n = ST_ENTRY;
        end else if (r_press[3]) begin
          w_valid_n = 1'b0;
          w_state_n = ST_ENTRY;
        end
      end
      ST_SHOW: begin
        if (bus.cpu_take_i) begin
          w_valid_n = 1'b0;
          w_tens_n  = '0;
          w_ones_n  = '0;
        end
        // Exit target uses the post-take valid so a same-cycle take never leaves PENDING empty
        if (r_press[3] || r_press[2])
          w_state_n = w_valid_n ? ST_PENDING : ST_ENTRY;
        else if (r_press[1] || r_press[0])
          w_show_pc_n = ~r_show_pc;
      end
      default: w_state_n = ST_ENTRY;
    endcase
    if (bus.out_i) begin
      w_res_n     = bus.res_i;
      w_pc_n      = bus.pc_i;
      w_show_pc_n = 1'b0;
      w_state_n   = ST_SHOW;
    end
  end

  assign bus.data_o       = r_data;
  assign bus.data_valid_o = r_valid;
  assign bus.state_o      = r_state;
  assign bus.disp_sel_o   = (r_state == ST_SHOW) ? (r_show_pc ? 2'd2 : 2'd1) : 2'd0;
  assign bus.disp_o       = (r_state == ST_SHOW)    ? (r_show_pc ? r_pc : r_res) :
                            (r_state == ST_PENDING) ? r_data : w_value_ext;

endmodule

// File: tb/tb_io_entry_ctrl.sv
// tb/tb_io_entry_ctrl.sv - self-checking bench for io_entry_ctrl
module tb_io_entry_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  io_entry_if #(.DW(32)) bus ();

  io_entry_ctrl #(.DB_CYCLES(N), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: keys as raw-sample run lengths, entry as integer digits
  int          m_state, m_tens, m_ones, m_valid, m_showpc;
  logic [31:0] m_data, m_res, m_pc;
  int          run [4];
  bit          fa [4], fb [4], mp [4];

  always @(posedge clk) begin : model
    bit raw [4];
    int ev;
    raw[0] = bus.k2_ge;
    raw[1] = bus.k1_ten;
    raw[2] = bus.k_enter;
    raw[3] = bus.k_cancel;
    if (rst) begin
      m_state = 0; m_tens = 0; m_ones = 0; m_valid = 0; m_showpc = 0;
      m_data = 0; m_res = 0; m_pc = 0;
      for (int k = 0; k < 4; k++) begin
        run[k] = 0; fa[k] = 0; fb[k] = 0; mp[k] = 0;
      end
    end else begin
      ev = -1;
      for (int k = 0; k < 4; k++) if (mp[k]) ev = k;
      case (m_state)
        0: begin
          if (ev == 3) begin m_tens = 0; m_ones = 0; end
          else if (ev == 2) begin m_data = m_tens * 10 + m_ones; m_valid = 1; m_state = 1; end
          else if (ev == 1) m_tens = (m_tens + 1) % 10;
          else if (ev == 0) m_ones = (m_ones + 1) % 10;
        end
        1: begin
          if (bus.cpu_take_i) begin m_valid = 0; m_tens = 0; m_ones = 0; m_state = 0; end
          else if (ev == 3) begin m_valid = 0; m_state = 0; end
        end
        default: begin
          if (bus.cpu_take_i) begin m_valid = 0; m_tens = 0; m_ones = 0; end
          if (ev >= 2) m_state = m_valid ? 1 : 0;
          else if (ev >= 0) m_showpc = !m_showpc;
        end
      endcase
      if (bus.out_i) begin
        m_res = bus.res_i; m_pc = bus.pc_i; m_showpc = 0; m_state = 2;
      end
      // A press is seen two edges after the raw run first reaches N samples
      for (int k = 0; k < 4; k++) begin
        mp[k] = fb[k];
        fb[k] = fa[k];
        run[k] = raw[k] ? ((run[k] > N) ? N + 1 : run[k] + 1) : 0;
        fa[k] = (run[k] == N);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [31:0] ed;
    logic [31:0] es;
    if (chk_en) begin
      es = (m_state == 2) ? (m_showpc ? 2 : 1) : 0;
      ed = (m_state == 2) ? (m_showpc ? m_pc : m_res) :
           (m_state == 1) ? m_data : 32'(m_tens * 10 + m_ones);
      chk("state", 32'(bus.state_o), 32'(m_state));
      chk("valid", 32'(bus.data_valid_o), 32'(m_valid));
      chk("data", bus.data_o, m_data);
      chk("disp_sel", 32'(bus.disp_sel_o), es);
      chk("disp", bus.disp_o, ed);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.k2_ge = v;
      1: bus.k1_ten = v;
      2: bus.k_enter = v;
      default: bus.k_cancel = v;
    endcase
  endtask

  task automatic press(input int k, input int times);
    for (int t = 0; t < times; t++) begin
      set_key(k, 1'b1);
      step(8);
      set_key(k, 1'b0);
      step(4);
    end
  endtask

  task automatic pulse_take();
    bus.cpu_take_i = 1'b1;
    step(1);
    bus.cpu_take_i = 1'b0;
  endtask

  initial begin
    bus.k1_ten = 0; bus.k2_ge = 0; bus.k_enter = 0; bus.k_cancel = 0;
    bus.cpu_take_i = 0; bus.out_i = 0; bus.res_i = 0; bus.pc_i = 0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_disp", bus.disp_o, 32'd0);
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_valid", 32'(bus.data_valid_o), 32'd0);

    // Digit entry
    press(0, 3);
    press(1, 2);
    chk("entry_23", bus.disp_o, 32'd23);
    chk("entry_state", 32'(bus.state_o), 32'd0);

    // Bounce rejection
    set_key(1, 1'b1); step(3); set_key(1, 1'b0); step(6);
    chk("bounce_short", bus.disp_o, 32'd23);
    for (int i = 0; i < 12; i++) begin
      set_key(1, 1'b1); step(1); set_key(1, 1'b0); step(1);
    end
    step(6);
    chk("bounce_alt", bus.disp_o, 32'd23);

    // Ones wrap from 0
    press(3, 1);
    chk("cancel_clear", bus.disp_o, 32'd0);
    press(0, 10);
    chk("wrap_ones", bus.disp_o, 32'd0);

    // Commit and take
    press(1, 2);
    press(0, 3);
    press(2, 1);
    chk("commit_valid", 32'(bus.data_valid_o), 32'd1);
    chk("commit_data", bus.data_o, 32'd23);
    chk("commit_state", 32'(bus.state_o), 32'd1);
    press(0, 1);
    chk("pending_ignore", bus.disp_o, 32'd23);
    pulse_take();
    chk("take_valid", 32'(bus.data_valid_o), 32'd0);
    chk("take_disp", bus.disp_o, 32'd0);
    chk("take_state", 32'(bus.state_o), 32'd0);

    // Result display from PENDING
    press(0, 1);
    press(2, 1);
    bus.res_i = 32'h1234; bus.pc_i = 32'h40; bus.out_i = 1'b1;
    step(1);
    bus.out_i = 1'b0; bus.res_i = 0; bus.pc_i = 0;
    chk("show_state", 32'(bus.state_o), 32'd2);
    chk("show_res", bus.disp_o, 32'h1234);
    chk("show_sel1", 32'(bus.disp_sel_o), 32'd1);
    press(0, 1);
    chk("show_pc", bus.disp_o, 32'h40);
    chk("show_sel2", 32'(bus.disp_sel_o), 32'd2);
    press(2, 1);
    chk("exit_state", 32'(bus.state_o), 32'd1);
    chk("exit_valid", 32'(bus.data_valid_o), 32'd1);
    chk("exit_disp", bus.disp_o, 32'd1);

    // Reset aborts the hand-off
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_valid", 32'(bus.data_valid_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_disp", bus.disp_o, 32'd0);

    // Randomized traffic against the model
    for (int seg = 0; seg < 300; seg++) begin
      int dur;
      bus.k2_ge    = ($urandom_range(0, 3) == 0);
      bus.k1_ten   = ($urandom_range(0, 3) == 0);
      bus.k_enter  = ($urandom_range(0, 3) == 0);
      bus.k_cancel = ($urandom_range(0, 7) == 0);
      dur = $urandom_range(1, 10);
      for (int c = 0; c < dur; c++) begin
        bus.cpu_take_i = ($urandom_range(0, 9) == 0);
        bus.out_i      = ($urandom_range(0, 24) == 0);
        bus.res_i      = $urandom;
        bus.pc_i       = $urandom;
        rst            = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    bus.k1_ten = 0; bus.k2_ge = 0; bus.k_enter = 0; bus.k_cancel = 0;
    bus.cpu_take_i = 0; bus.out_i = 0; rst = 1'b0;
    step(10);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
